// File: rtl/minitb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : minitb_pkg
// Description : Shared branch opcodes, execution sub-cycle indices and the
//               branch-condition helper for the branch target unit.
// Revision    : 1.0 - initial release
// ============================================================================
package minitb_pkg;

    localparam logic [2:0] BR_NOP  = 3'd0;
    localparam logic [2:0] BR_JMP  = 3'd1;
    localparam logic [2:0] BR_JC   = 3'd2;
    localparam logic [2:0] BR_JNC  = 3'd3;
    localparam logic [2:0] BR_JZ   = 3'd4;
    localparam logic [2:0] BR_JNZ  = 3'd5;
    localparam logic [2:0] BR_CALL = 3'd6;
    localparam logic [2:0] BR_RET  = 3'd7;

    localparam logic [2:0] CYC_IMM_H  = 3'd1;
    localparam logic [2:0] CYC_IMM_M  = 3'd2;
    localparam logic [2:0] CYC_IMM_L  = 3'd3;
    localparam logic [2:0] CYC_DECIDE = 3'd6;
    localparam logic [2:0] CYC_COMMIT = 3'd7;

    localparam int DEFAULT_ADDR_W = 12;

    // ret_ok carries "a return address is available"; forced low when the
    // call/return feature is absent so RET degenerates to NOP.
    function automatic logic br_condition(
        input logic [2:0] op,
        input logic       carry,
        input logic       zero,
        input logic       ret_ok
    );
        logic met;
        case (op)
            BR_JMP, BR_CALL: met = 1'b1;
            BR_JC:           met = carry;
            BR_JNC:          met = ~carry;
            BR_JZ:           met = zero;
            BR_JNZ:          met = ~zero;
            BR_RET:          met = ret_ok;
            default:         met = 1'b0;
        endcase
        return met;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ret_stack.sv
`default_nettype none
// ============================================================================
// Module      : ret_stack
// Description : Return-address LIFO. Entry 0 is always top-of-stack; push
//               shifts down, pop shifts up. Push wins over a same-cycle pop.
// Revision    : 1.0 - initial release
// ============================================================================
module ret_stack
    import minitb_pkg::*;
#(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = DEFAULT_ADDR_W,
    localparam int CNT_W = $clog2(DEPTH + 1)
)(
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] top,
    output logic [CNT_W-1:0] depth,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [CNT_W-1:0] r_depth;
    logic             w_do_push;
    logic             w_do_pop;

    assign full      = (r_depth == CNT_W'(DEPTH));
    assign empty     = (r_depth == '0);
    assign w_do_push = push & ~full;
    assign w_do_pop  = pop & ~empty & ~push;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_depth <= '0;
        end else if (w_do_push) begin
            r_mem[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                r_mem[i] <= r_mem[i-1];
            end
            r_depth <= r_depth + CNT_W'(1);
        end else if (w_do_pop) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                r_mem[i] <= r_mem[i+1];
            end
            r_mem[DEPTH-1] <= '0;
            r_depth        <= r_depth - CNT_W'(1);
        end
    end

    assign top   = r_mem[0];
    assign depth = r_depth;

endmodule
`default_nettype wire

// File: rtl/branch_target_unit.sv
`default_nettype none
// ============================================================================
// Module      : branch_target_unit
// Description : Builds the PC jump request from three immediate nibbles and the
//               ALU flags; optional CALL/RET return stack (BRANCH_CALL_RET_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module branch_target_unit
    import minitb_pkg::*;
#(
    parameter int STACK_DEPTH = 4,
    parameter int ADDR_W      = DEFAULT_ADDR_W
)(
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             cpuCe,
    input  logic [2:0]                       cycle,
    input  logic [2:0]                       brOp,
    input  logic [3:0]                       imm,
    input  logic                             carryFlag,
    input  logic                             zeroFlag,
    input  logic [ADDR_W-1:0]                pcount,
    output logic                             jump,
    output logic [ADDR_W-1:0]                jumpAddr,
    output logic [$clog2(STACK_DEPTH+1)-1:0] stackDepth,
    output logic                             stackOvf,
    output logic                             stackUnf
);

    localparam int c_depth_w = $clog2(STACK_DEPTH + 1);

    logic [3:0]        r_imm_h;
    logic [3:0]        r_imm_m;
    logic [3:0]        r_imm_l;
    logic              r_jump;
    logic [ADDR_W-1:0] r_jump_addr;

    logic [ADDR_W-1:0] w_target;
    logic [ADDR_W-1:0] w_ret_addr;
    logic [ADDR_W-1:0] w_next_addr;
    logic              w_ret_ok;
    logic              w_taken;
    logic              w_decide;
    logic              w_commit;

    assign w_decide = cpuCe & (cycle == CYC_DECIDE);
    assign w_commit = cpuCe & (cycle == CYC_COMMIT);
    assign w_target = ADDR_W'({r_imm_h, r_imm_m, r_imm_l});
    assign w_taken  = br_condition(brOp, carryFlag, zeroFlag, w_ret_ok);

    // Only a taken RET redirects to the stack; everything else carries the latched target.
    assign w_next_addr = ((brOp == BR_RET) && w_taken) ? w_ret_addr : w_target;

`ifdef BRANCH_CALL_RET_EN
    logic                 r_push_pend;
    logic                 r_pop_pend;
    logic                 r_ovf;
    logic                 r_unf;
    logic                 w_full;
    logic                 w_empty;
    logic [ADDR_W-1:0]    w_top;
    logic [c_depth_w-1:0] w_depth;

    ret_stack #(
        .DEPTH (STACK_DEPTH),
        .WIDTH (ADDR_W)
    ) u_ret_stack (
        .clk   (clk),
        .reset (reset),
        .push  (w_commit & r_push_pend),
        .pop   (w_commit & r_pop_pend),
        .din   (pcount + ADDR_W'(1)),
        .top   (w_top),
        .depth (w_depth),
        .full  (w_full),
        .empty (w_empty)
    );

    assign w_ret_ok   = ~w_empty;
    assign w_ret_addr = w_top;

    // Stack decision is taken with the branch, applied one frame-cycle later
    // when the PC consumes the request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_push_pend <= 1'b0;
            r_pop_pend  <= 1'b0;
            r_ovf       <= 1'b0;
            r_unf       <= 1'b0;
        end else if (w_decide) begin
            r_push_pend <= (brOp == BR_CALL) & ~w_full;
            r_pop_pend  <= (brOp == BR_RET) & ~w_empty;
            r_ovf       <= r_ovf | ((brOp == BR_CALL) & w_full);
            r_unf       <= r_unf | ((brOp == BR_RET) & w_empty);
        end else if (w_commit) begin
            r_push_pend <= 1'b0;
            r_pop_pend  <= 1'b0;
        end
    end

    assign stackDepth = w_depth;
    assign stackOvf   = r_ovf;
    assign stackUnf   = r_unf;
`else
    logic w_unused_pcount;

    assign w_ret_ok        = 1'b0;
    assign w_ret_addr      = '0;
    assign w_unused_pcount = ^pcount;
    assign stackDepth      = '0;
    assign stackOvf        = 1'b0;
    assign stackUnf        = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_imm_h     <= '0;
            r_imm_m     <= '0;
            r_imm_l     <= '0;
            r_jump      <= 1'b0;
            r_jump_addr <= '0;
        end else if (cpuCe) begin
            case (cycle)
                CYC_IMM_H: r_imm_h <= imm;
                CYC_IMM_M: r_imm_m <= imm;
                CYC_IMM_L: r_imm_l <= imm;
                CYC_DECIDE: begin
                    r_jump      <= w_taken;
                    r_jump_addr <= w_next_addr;
                end
                CYC_COMMIT: r_jump <= 1'b0;
                default: ;
            endcase
        end
    end

    assign jump     = r_jump;
    assign jumpAddr = r_jump_addr;

endmodule
`default_nettype wire

// File: tb/tb_branch_target_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_target_unit
// Description : Table vectors, directed CALL/RET/reset/stall sequences and
//               random frames checked against a queue-based return-stack model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_target_unit;

    localparam int DEPTH = 4;
`ifdef BRANCH_CALL_RET_EN
    localparam bit EN = 1'b1;
`else
    localparam bit EN = 1'b0;
`endif

    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_JMP  = 3'd1;
    localparam logic [2:0] OP_JC   = 3'd2;
    localparam logic [2:0] OP_JNC  = 3'd3;
    localparam logic [2:0] OP_JZ   = 3'd4;
    localparam logic [2:0] OP_JNZ  = 3'd5;
    localparam logic [2:0] OP_CALL = 3'd6;
    localparam logic [2:0] OP_RET  = 3'd7;

    logic                         clk = 1'b0;
    logic                         reset;
    logic                         cpuCe;
    logic [2:0]                   cycle;
    logic [2:0]                   brOp;
    logic [3:0]                   imm;
    logic                         carryFlag;
    logic                         zeroFlag;
    logic [11:0]                  pcount;
    logic                         jump;
    logic [11:0]                  jumpAddr;
    logic [$clog2(DEPTH+1)-1:0]   stackDepth;
    logic                         stackOvf;
    logic                         stackUnf;

    int          n_checks = 0;
    int          n_err    = 0;
    int unsigned m_stack[$];
    bit          m_ovf;
    bit          m_unf;
    logic        obs_jump;
    logic [11:0] obs_addr;

    typedef struct {
        logic [2:0]  op;
        logic [11:0] tgt;
        logic        c;
        logic        z;
        logic        ej;
    } vec_t;
    vec_t tbl[9];

    branch_target_unit #(
        .STACK_DEPTH (DEPTH),
        .ADDR_W      (12)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cpuCe      (cpuCe),
        .cycle      (cycle),
        .brOp       (brOp),
        .imm        (imm),
        .carryFlag  (carryFlag),
        .zeroFlag   (zeroFlag),
        .pcount     (pcount),
        .jump       (jump),
        .jumpAddr   (jumpAddr),
        .stackDepth (stackDepth),
        .stackOvf   (stackOvf),
        .stackUnf   (stackUnf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Inputs outside their windows are randomised; they must not matter.
    task automatic drive(input int cy, input logic [2:0] op, input logic [11:0] tgt,
                         input logic c, input logic z, input logic [11:0] pc);
        cycle = 3'(cy);
        brOp  = (cy >= 1 && cy <= 6) ? op : 3'($urandom);
        case (cy)
            1:       imm = tgt[11:8];
            2:       imm = tgt[7:4];
            3:       imm = tgt[3:0];
            default: imm = 4'($urandom);
        endcase
        carryFlag = (cy == 6) ? c : 1'($urandom);
        zeroFlag  = (cy == 6) ? z : 1'($urandom);
        pcount    = pc;
    endtask

    task automatic model(input logic [2:0] op, input logic [11:0] tgt, input logic c,
                         input logic z, input logic [11:0] pc,
                         output logic ej, output logic [11:0] ea);
        ea = tgt;
        case (op)
            OP_JMP:  ej = 1'b1;
            OP_JC:   ej = c;
            OP_JNC:  ej = !c;
            OP_JZ:   ej = z;
            OP_JNZ:  ej = !z;
            OP_CALL: begin
                ej = 1'b1;
                if (EN) begin
                    if (m_stack.size() < DEPTH) m_stack.push_back((int'(pc) + 1) % 4096);
                    else                        m_ovf = 1'b1;
                end
            end
            OP_RET: begin
                ej = 1'b0;
                if (EN) begin
                    if (m_stack.size() > 0) begin
                        ej = 1'b1;
                        ea = 12'(m_stack.pop_back());
                    end else begin
                        m_unf = 1'b1;
                    end
                end
            end
            default: ej = 1'b0;
        endcase
    endtask

    // One 8-cycle frame; optionally freeze cpuCe for 3 clocks at cycle stall_at.
    task automatic frame(input logic [2:0] op, input logic [11:0] tgt, input logic c,
                         input logic z, input logic [11:0] pc,
                         input logic ej, input logic [11:0] ea, input int stall_at);
        for (int cy = 0; cy < 8; cy++) begin
            drive(cy, op, tgt, c, z, pc);
            if (cy == 7) begin
                obs_jump = jump;
                obs_addr = jumpAddr;
                chk("jump_c7", jump, ej);
                if (ej) chk("addr_c7", jumpAddr, ea);
            end else if (cy == 4) begin
                chk("jump_idle", jump, 1'b0);
            end
            if (cy == stall_at) begin
                cpuCe = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    cycle     = 3'($urandom);
                    brOp      = 3'($urandom);
                    imm       = 4'($urandom);
                    carryFlag = 1'($urandom);
                    zeroFlag  = 1'($urandom);
                    @(posedge clk); #1;
                    chk("jump_stall", jump, (cy == 7) ? ej : 1'b0);
                end
                drive(cy, op, tgt, c, z, pc);
                cpuCe = 1'b1;
            end
            @(posedge clk); #1;
        end
        chk("jump_c0", jump, 1'b0);
        if (ej) chk("addr_held", jumpAddr, ea);
        chk("depth", stackDepth, m_stack.size());
        chk("ovf", stackOvf, m_ovf);
        chk("unf", stackUnf, m_unf);
    endtask

    task automatic mframe(input logic [2:0] op, input logic [11:0] tgt, input logic c,
                          input logic z, input logic [11:0] pc, input int stall_at);
        logic        ej;
        logic [11:0] ea;
        model(op, tgt, c, z, pc, ej, ea);
        frame(op, tgt, c, z, pc, ej, ea, stall_at);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; cpuCe = 1'b1; cycle = '0; brOp = '0; imm = '0;
        carryFlag = 1'b0; zeroFlag = 1'b0; pcount = '0;
        m_ovf = 1'b0; m_unf = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_jump", jump, 1'b0);
        chk("rst_addr", jumpAddr, 12'h000);
        chk("rst_depth", stackDepth, 0);
        chk("rst_ovf", stackOvf, 1'b0);
        chk("rst_unf", stackUnf, 1'b0);
        reset = 1'b0;

        tbl[0] = '{OP_JMP, 12'hA53, 1'b0, 1'b0, 1'b1};
        tbl[1] = '{OP_JC,  12'h123, 1'b0, 1'b1, 1'b0};
        tbl[2] = '{OP_JC,  12'h123, 1'b1, 1'b0, 1'b1};
        tbl[3] = '{OP_JNC, 12'h456, 1'b0, 1'b1, 1'b1};
        tbl[4] = '{OP_JNC, 12'h456, 1'b1, 1'b0, 1'b0};
        tbl[5] = '{OP_JZ,  12'h789, 1'b0, 1'b1, 1'b1};
        tbl[6] = '{OP_JZ,  12'h789, 1'b1, 1'b0, 1'b0};
        tbl[7] = '{OP_JNZ, 12'hABC, 1'b1, 1'b0, 1'b1};
        tbl[8] = '{OP_NOP, 12'hFFF, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 9; i++) begin
            frame(tbl[i].op, tbl[i].tgt, tbl[i].c, tbl[i].z, 12'h050,
                  tbl[i].ej, tbl[i].tgt, -1);
        end

        // CALL / RET round trip, including PC wrap at 0xFFF
        mframe(OP_CALL, 12'h200, 1'b0, 1'b0, 12'h010, -1);
        chk("call_addr", obs_addr, 12'h200);
        chk("call_depth", stackDepth, EN ? 1 : 0);
        mframe(OP_RET, 12'h7E7, 1'b0, 1'b0, 12'h200, -1);
        chk("ret_jump", obs_jump, EN);
        chk("ret_depth", stackDepth, 0);
        mframe(OP_CALL, 12'h345, 1'b1, 1'b1, 12'hFFF, -1);
        mframe(OP_RET, 12'h111, 1'b1, 1'b1, 12'h345, -1);

        // Overflow then underflow
        for (int i = 0; i < 5; i++) begin
            mframe(OP_CALL, 12'(12'h300 + i), 1'b0, 1'b0, 12'(i * 16 + 5), -1);
        end
        chk("ovf5_jump", obs_jump, 1'b1);
        chk("ovf5_depth", stackDepth, EN ? 4 : 0);
        chk("ovf5_flag", stackOvf, EN);
        for (int i = 0; i < 5; i++) begin
            mframe(OP_RET, 12'h0F0, 1'b0, 1'b0, 12'h300, -1);
        end
        chk("unf5_jump", obs_jump, 1'b0);
        chk("unf5_flag", stackUnf, EN);

        // cpuCe freeze at the decision cycle and during target capture
        mframe(OP_JMP, 12'h5A5, 1'b0, 1'b0, 12'h080, 6);
        mframe(OP_JNZ, 12'hC3C, 1'b0, 1'b0, 12'h080, 2);

        // Reset in the decision cycle of a taken CALL: request and push discarded
        for (int cy = 0; cy < 7; cy++) begin
            drive(cy, OP_CALL, 12'h3C5, 1'b0, 1'b0, 12'h100);
            @(posedge clk); #1;
        end
        chk("pre_reset_jump", jump, 1'b1);
        reset = 1'b1;
        #1;
        chk("reset_async_jump", jump, 1'b0);
        chk("reset_async_addr", jumpAddr, 12'h000);
        chk("reset_async_ovf", stackOvf, 1'b0);
        #1;
        reset = 1'b0;
        m_stack.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        drive(7, OP_CALL, 12'h3C5, 1'b0, 1'b0, 12'h100);
        #1;
        chk("reset_no_c7", jump, 1'b0);
        @(posedge clk); #1;
        chk("reset_no_push", stackDepth, 0);

        // Random frames against the model
        for (int i = 0; i < 60; i++) begin
            logic [2:0]  op;
            logic [11:0] tgt;
            logic [11:0] pc;
            int          st;
            op  = 3'($urandom);
            tgt = 12'($urandom);
            pc  = ($urandom_range(0, 7) == 0) ? 12'hFFF : 12'($urandom);
            st  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : -1;
            mframe(op, tgt, 1'($urandom), 1'($urandom), pc, st);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
